// File: rtl/svc_rv_hazard_pkg.sv
// Shared types and constants for the RV pipeline hazard sequencer.
package svc_rv_hazard_pkg;

  localparam int unsigned HZ_CNT_W       = 6;
  localparam int unsigned FUNCT3_DIV_BIT = 2;
  localparam int unsigned REG_ADDR_W     = 5;
  localparam int unsigned PERF_W         = 32;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    DIV_BUSY = 2'd2
  } hazard_state_t;

  // Stall/flush bundle driven toward the pipeline registers
  typedef struct packed {
    logic stall_pc;
    logic stall_if_id;
    logic stall_id_ex;
    logic flush_if_id;
    logic flush_id_ex;
    logic flush_ex_mem;
    logic div_done;
  } hazard_ctl_t;

endpackage

// File: rtl/svc_rv_hazard_detect.sv
// Combinational load-use and multi-cycle divide detection for the hazard sequencer.
module svc_rv_hazard_detect
  import svc_rv_hazard_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] rs1_id_i,
  input  logic [REG_ADDR_W-1:0] rs2_id_i,
  input  logic                  rs1_used_id_i,
  input  logic                  rs2_used_id_i,
  input  logic [REG_ADDR_W-1:0] rd_ex_i,
  input  logic                  mem_read_ex_i,
  input  logic                  is_m_ex_i,
  input  logic [2:0]            funct3_ex_i,
  output logic                  load_use_c,
  output logic                  div_ex_c
);

  logic rs1_hit_c;
  logic rs2_hit_c;
  logic unused_funct3_c;

  assign rs1_hit_c  = rs1_used_id_i && (rs1_id_i == rd_ex_i);
  assign rs2_hit_c  = rs2_used_id_i && (rs2_id_i == rd_ex_i);
  // x0 is never a real producer, so a load to it cannot create a hazard
  assign load_use_c = mem_read_ex_i && (rd_ex_i != '0) && (rs1_hit_c || rs2_hit_c);
  assign div_ex_c   = is_m_ex_i && funct3_ex_i[FUNCT3_DIV_BIT];

  assign unused_funct3_c = ^funct3_ex_i;

endmodule

// File: rtl/svc_rv_hazard_ctrl.sv
// Stall/flush sequencer for load-use, multi-cycle divide, mispredict and redirect.
// Define SVC_RV_HAZARD_PERF_EN to build the saturating perf counters.
module svc_rv_hazard_ctrl
  import svc_rv_hazard_pkg::*;
#(
  parameter int unsigned DIV_CYCLES   = 32,
  parameter int unsigned LOAD_BUBBLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] rs1_id,
  input  logic [REG_ADDR_W-1:0] rs2_id,
  input  logic                  rs1_used_id,
  input  logic                  rs2_used_id,
  input  logic [REG_ADDR_W-1:0] rd_ex,
  input  logic                  mem_read_ex,
  input  logic                  is_m_ex,
  input  logic [2:0]            funct3_ex,
  input  logic                  mispredict_ex,
  input  logic                  redirect,
  output logic                  stall_pc,
  output logic                  stall_if_id,
  output logic                  stall_id_ex,
  output logic                  flush_if_id,
  output logic                  flush_id_ex,
  output logic                  flush_ex_mem,
  output logic                  div_done,
  output logic                  busy,
  output logic [PERF_W-1:0]     perf_lu_stalls,
  output logic [PERF_W-1:0]     perf_div_stalls,
  output logic [PERF_W-1:0]     perf_flushes
);

  localparam logic [HZ_CNT_W-1:0] DIV_INIT =
    HZ_CNT_W'((DIV_CYCLES > 1) ? DIV_CYCLES - 2 : 0);
  localparam logic [HZ_CNT_W-1:0] LU_INIT =
    HZ_CNT_W'((LOAD_BUBBLES > 1) ? LOAD_BUBBLES - 2 : 0);

  hazard_state_t         state_q, state_d;
  logic [HZ_CNT_W-1:0]   cnt_q, cnt_d;
  hazard_ctl_t           ctl_c;
  logic                  load_use_c;
  logic                  div_ex_c;
  logic                  lu_stall_c;
  logic                  div_stall_c;

  svc_rv_hazard_detect u_detect (
    .rs1_id_i      (rs1_id),
    .rs2_id_i      (rs2_id),
    .rs1_used_id_i (rs1_used_id),
    .rs2_used_id_i (rs2_used_id),
    .rd_ex_i       (rd_ex),
    .mem_read_ex_i (mem_read_ex),
    .is_m_ex_i     (is_m_ex),
    .funct3_ex_i   (funct3_ex),
    .load_use_c    (load_use_c),
    .div_ex_c      (div_ex_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ctl_c       = '0;
    lu_stall_c  = 1'b0;
    div_stall_c = 1'b0;
    unique case (state_q)
      RUN: begin
        if (redirect) begin
          ctl_c.flush_if_id  = 1'b1;
          ctl_c.flush_id_ex  = 1'b1;
          ctl_c.flush_ex_mem = 1'b1;
        end else if (mispredict_ex) begin
          ctl_c.flush_if_id = 1'b1;
          ctl_c.flush_id_ex = 1'b1;
        end else if (div_ex_c) begin
          if (DIV_CYCLES > 1) begin
            ctl_c.stall_pc     = 1'b1;
            ctl_c.stall_if_id  = 1'b1;
            ctl_c.stall_id_ex  = 1'b1;
            ctl_c.flush_ex_mem = 1'b1;
            cnt_d              = DIV_INIT;
            state_d            = DIV_BUSY;
          end else begin
            ctl_c.div_done = 1'b1;
          end
        end else if (load_use_c) begin
          ctl_c.stall_pc    = 1'b1;
          ctl_c.stall_if_id = 1'b1;
          ctl_c.flush_id_ex = 1'b1;
          lu_stall_c        = 1'b1;
          if (LOAD_BUBBLES > 1) begin
            cnt_d   = LU_INIT;
            state_d = LU_STALL;
          end
        end
      end
      LU_STALL: begin
        if (redirect) begin
          ctl_c.flush_if_id  = 1'b1;
          ctl_c.flush_id_ex  = 1'b1;
          ctl_c.flush_ex_mem = 1'b1;
          cnt_d              = '0;
          state_d            = RUN;
        end else begin
          ctl_c.stall_pc    = 1'b1;
          ctl_c.stall_if_id = 1'b1;
          ctl_c.flush_id_ex = 1'b1;
          lu_stall_c        = 1'b1;
          if (cnt_q == '0) state_d = RUN;
          else             cnt_d   = cnt_q - HZ_CNT_W'(1);
        end
      end
      DIV_BUSY: begin
        // Redirect abandons the divide without ever signalling completion
        if (redirect) begin
          ctl_c.flush_if_id  = 1'b1;
          ctl_c.flush_id_ex  = 1'b1;
          ctl_c.flush_ex_mem = 1'b1;
          cnt_d              = '0;
          state_d            = RUN;
        end else if (cnt_q != '0) begin
          ctl_c.stall_pc     = 1'b1;
          ctl_c.stall_if_id  = 1'b1;
          ctl_c.stall_id_ex  = 1'b1;
          ctl_c.flush_ex_mem = 1'b1;
          div_stall_c        = 1'b1;
          cnt_d              = cnt_q - HZ_CNT_W'(1);
        end else begin
          ctl_c.div_done = 1'b1;
          state_d        = RUN;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = RUN;
      end
    endcase
  end

  // Reset forces every control output low regardless of the inputs
  assign stall_pc     = rst_n && ctl_c.stall_pc;
  assign stall_if_id  = rst_n && ctl_c.stall_if_id;
  assign stall_id_ex  = rst_n && ctl_c.stall_id_ex;
  assign flush_if_id  = rst_n && ctl_c.flush_if_id;
  assign flush_id_ex  = rst_n && ctl_c.flush_id_ex;
  assign flush_ex_mem = rst_n && ctl_c.flush_ex_mem;
  assign div_done     = rst_n && ctl_c.div_done;
  assign busy         = rst_n && (state_q != RUN);

`ifdef SVC_RV_HAZARD_PERF_EN
  logic [PERF_W-1:0] perf_lu_q;
  logic [PERF_W-1:0] perf_div_q;
  logic [PERF_W-1:0] perf_fl_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_lu_q  <= '0;
      perf_div_q <= '0;
      perf_fl_q  <= '0;
    end else begin
      if (lu_stall_c && (perf_lu_q != '1))         perf_lu_q  <= perf_lu_q + PERF_W'(1);
      if (div_stall_c && (perf_div_q != '1))       perf_div_q <= perf_div_q + PERF_W'(1);
      if (ctl_c.flush_if_id && (perf_fl_q != '1))  perf_fl_q  <= perf_fl_q + PERF_W'(1);
    end
  end

  assign perf_lu_stalls  = perf_lu_q;
  assign perf_div_stalls = perf_div_q;
  assign perf_flushes    = perf_fl_q;
`else
  logic unused_perf_c;
  assign unused_perf_c   = lu_stall_c ^ div_stall_c;
  assign perf_lu_stalls  = '0;
  assign perf_div_stalls = '0;
  assign perf_flushes    = '0;
`endif

endmodule
